// File: rtl/parity_frame_checker_if.sv
// Bus between a serial bit source and the receive-side parity checker.
// The master drives frame start and qualified bits. The slave returns busy,
// the reassembled word, the parity verdict and the completion strobe.
interface parity_frame_checker_if #(
    parameter int DATA_BITS = 8
);
    logic                 start;
    logic                 bit_in;
    logic                 bit_valid;
    logic                 busy;
    logic [DATA_BITS-1:0] data_out;
    logic                 parity_err;
    logic                 done;

    modport master (
        output start, bit_in, bit_valid,
        input  busy, data_out, parity_err, done
    );

    modport slave (
        input  start, bit_in, bit_valid,
        output busy, data_out, parity_err, done
    );
endinterface

// File: rtl/parity_frame_checker.sv
// Serial receive-side parity checker.
// A frame is DATA_BITS data bits (LSB first) followed by one parity bit. Each
// bit is taken on a cycle with bit_valid high. The word is reassembled and
// parity is checked over data plus parity bit. The result is published with a
// one-cycle done strobe, and data_out/parity_err hold until the next done.
module parity_frame_checker #(
    parameter int DATA_BITS = 8,
    parameter bit ODD       = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    parity_frame_checker_if.slave   bus
);
    // The counter only has to reach DATA_BITS-1, but it is sized for DATA_BITS
    // so that a single-bit frame still gets a non-zero width.
    localparam int CW = $clog2(DATA_BITS + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 acc_q, acc_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;

    logic                 sh_clr;
    logic                 sh_load;

    // The shift register is cleared on an accepted start. It captures bit_in
    // in data state on valid cycles only.
    assign sh_clr  = (state_q == S_IDLE) && bus.start;
    assign sh_load = (state_q == S_DATA) && bus.bit_valid;

    // Each position is written by index rather than shifted. Frame bit k
    // lands in position k directly, and this works for any width, including 1.
    generate
        for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_sh
            assign sh_d[gi] = sh_clr ? 1'b0 :
                              (sh_load && (cnt_q == CW'(gi))) ? bus.bit_in :
                              sh_q[gi];
        end
    endgenerate

    // FSM next state plus the counter, accumulator and output updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        data_d  = data_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // bit_valid is deliberately ignored here, even together with start.
                if (bus.start) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                end
            end
            S_DATA: begin
                if (bus.bit_valid) begin
                    acc_d = acc_q ^ bus.bit_in;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(DATA_BITS - 1)) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (bus.bit_valid) begin
                    data_d  = sh_q;
                    err_d   = acc_q ^ bus.bit_in ^ ODD;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers. Reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            acc_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // busy is decoded from the registered state. It rises on the edge that
    // accepts start and falls on the edge that samples the parity bit.
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.data_out   = data_q;
    assign bus.parity_err = err_q;
    assign bus.done       = done_q;
endmodule

// File: doc/parity_frame_checker.md
# parity_frame_checker

Serial receive-side parity checker, the receiving end of the 1-bit XOR parity generator. It accepts a frame of `DATA_BITS` data bits followed by one parity bit, LSB first, one bit per qualified clock. It reassembles the data word, checks even or odd parity over data plus parity bit, and reports the word, a one-cycle `done` strobe and a sticky-until-next-frame `parity_err` flag. It sits between the serial bit source and the word-level consumer.

## Interface
- `DATA_BITS`, default 8: number of data bits per frame; legal range 1–32.
- `ODD`, default 0: 0 = even parity (XOR of data and parity bit must be 0); 1 = odd parity (XOR must be 1).

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset; deassertion is synchronous to `clk` externally.
- `start`  in  1  frame-start pulse; accepted only when `busy`=0.
- `bit_in`  in  1  serial data/parity bit.
- `bit_valid`  in  1  qualifies `bit_in` in the current cycle.
- `busy`  out  1  high from the cycle after an accepted `start` until the parity bit is sampled.
- `data_out`  out  `DATA_BITS`  last received word; updated only together with `done`.
- `parity_err`  out  1  parity result of the last frame; updated only together with `done`.
- `done`  out  1  one-cycle pulse: frame complete, `data_out`/`parity_err` valid.

## Operation
- FSM states: IDLE, DATA, PARITY.
- IDLE: `busy`=0. If `start`=1, go to DATA, clear bit counter, shift register and parity accumulator. Any `bit_valid` in IDLE, including the same cycle as `start`, is ignored.
- DATA: on each `bit_valid`=1, shift `bit_in` into the shift register (bit k of the frame lands in `data_out[k]`, LSB first), XOR it into the accumulator, and increment the counter. On the valid bit with counter = `DATA_BITS`-1, go to PARITY. Cycles with `bit_valid`=0 leave all state unchanged; gaps of any length are allowed.
- PARITY: on `bit_valid`=1, compute err = acc ^ `bit_in` ^ `ODD`, load `data_out` ← shift register and `parity_err` ← err, and pulse `done`. Go to IDLE.
- `start` while `busy`=1 is ignored; there is no restart mid-frame.
- Counter width is ceil(log2(`DATA_BITS`+1)). The counter never wraps because the FSM leaves DATA at `DATA_BITS`-1.
- `data_out` and `parity_err` hold their values until the next `done`.

## Timing
- Reset values (async, immediate): state IDLE, `busy`=0, `done`=0, `parity_err`=0, `data_out`=0, counter, shift register and accumulator = 0.
- `busy` rises on the edge that samples `start`, and falls on the edge that samples the parity bit.
- `done`, `data_out` and `parity_err` are registered and become visible in the cycle after the parity bit is sampled. `done` is high for exactly one cycle.
- Back-to-back bits: `start` in cycle 0, data in cycles 1..`DATA_BITS`, parity in cycle `DATA_BITS`+1, `done` in cycle `DATA_BITS`+2.
- A new `start` is accepted in the same cycle that `done` is high, because the FSM is already in IDLE.
- Reset asserted mid-frame: the frame is discarded, no `done` is produced, and outputs return to their reset values.

## Test plan
- Even parity, DATA_BITS=8, back-to-back: start, bits of 0xA5 LSB first, parity 0 → `done` in cycle 10, `data_out`=0xA5, `parity_err`=0.
- Same frame with parity bit 1 → `done` in cycle 10, `data_out`=0xA5, `parity_err`=1. Then a frame 0x01 with parity 1 → `parity_err`=0, proving the flag is updated per frame.
- `ODD`=1: frame 0x00 with parity 1 → `parity_err`=0. Frame 0x00 with parity 0 → `parity_err`=1.
- Random 0–3 cycle gaps in `bit_valid` during frame 0x3C, parity 0 → `data_out`=0x3C, `parity_err`=0, exactly one `done`. `start` pulses sent while `busy`=1 are ignored; `bit_valid` sent in IDLE causes no change.
- `rst_n` pulled low after 4 data bits → `busy`=0 and outputs 0 immediately, no `done`. After release, a clean frame 0xFF with parity 0 → `data_out`=0xFF, `parity_err`=0.
- Back-to-back frames 0x12 then 0x34, with the second `start` in the `done` cycle → two `done` pulses 10 cycles apart with correct words.
